spr_sched: RTL and testbench
============================

# spr_sched

Sprite evaluation and load scheduler for the eight `spr_rend` sprite render units. At each horizontal-blank start it scans the 64-entry sprite attribute memory (OAM) for sprites that intersect the next scanline. It fetches each hit's two pattern bit-planes over a request/acknowledge port, then loads each render unit in turn with a packed 32-bit render word and a one-hot load strobe. It sits between OAM, the pattern-memory arbiter and the `spr_rend` array, and it drives each unit's `draw` enable.

## Interface
Parameters:
- `NUM_SLOTS`, 8: number of `spr_rend` units served (1–8).
- `NUM_OAM`, 64: OAM entries scanned per line.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `line_start` in 1: one-cycle pulse at hblank start; `scanline` is valid on this cycle.
- `scanline` in 8: line about to be drawn; captured on `line_start`.
- `oam_addr` out 6: OAM read address.
- `oam_data` in 32: {y[31:24], tile[23:16], attr[15:8], x[7:0]}; valid one cycle after `oam_addr`. attr[7]=vflip, attr[6]=hflip, attr[5]=priority, attr[1:0]=palette.
- `pat_req` out 1: pattern fetch request.
- `pat_addr` out 11: {tile, row[2:0]}.
- `pat_ack` in 1: fetch complete; `pat_data` is valid on this cycle.
- `pat_data` in 16: {plane1[15:8], plane0[7:0]}.
- `rend_buf` out 32: {1'b0, hflip[30], priority[29], 3'b0, palette[25:24], x[23:16], plane1[15:8], plane0[7:0]}.
- `rend_now` out NUM_SLOTS: one-hot load strobe per unit.
- `draw_en` out NUM_SLOTS: per-unit draw enable.
- `overflow` out 1: more than NUM_SLOTS sprites hit on the last evaluated line.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when the evaluation is complete.

## Operation
- Reset values: all outputs 0; state IDLE; hit count 0.
- States and transitions:
  - IDLE → SCAN on `line_start`. That cycle captures `scanline`, clears the hit buffer and sets `draw_en` to 0 (suppresses stale sprites).
  - SCAN issues `oam_addr` 0..NUM_OAM-1 on consecutive cycles. Each returned entry is tested one cycle later.
  - Hit test: row = scanline − y, 8-bit wrap. The entry is a hit iff row < 8.
  - For each hit, {row, tile, attr, x} is stored into the next free buffer slot, in OAM order.
  - If a hit is found with the buffer already full: `overflow` := 1 (SPR_OVERFLOW_EN only), and SCAN ends immediately.
  - SCAN → FETCH when hits > 0; SCAN → DONE when hits = 0.
  - FETCH (slot k): `pat_req` = 1; `pat_addr` = {tile, vflip ? 7−row : row}. Holds until `pat_ack`; `pat_data` is captured on the ack cycle. → LOAD.
  - LOAD: `rend_buf` is driven with slot k's word; `rend_now` = 0. → STROBE.
  - STROBE: `rend_buf` is held; `rend_now[k]` = 1 for exactly this cycle. Then go to FETCH for k+1, or to DONE after the last hit.
  - DONE: `done` = 1; `draw_en[i]` = 1 for i < hit count; `overflow` is updated. → IDLE.
- `rend_buf` changes only in LOAD. It is stable from the cycle before any `rend_now` rising edge through the cycle it falls.
- `line_start` while busy: the evaluation aborts and restarts as from IDLE in the same cycle. `rend_now` goes to 0 and no partial `done` is produced.
- `pat_req` is never withdrawn before `pat_ack`, except on abort or reset.
- Reset asserted mid-operation: all state and outputs return to their reset values immediately, with no handshake completion.

## Timing
- SCAN lasts NUM_OAM+1 cycles: addresses are pipelined, plus one tail compare cycle.
- Per loaded slot: (ack latency + 1) + 2 cycles. A same-cycle ack gives 3 cycles per slot.
- Best case, 8 hits with immediate ack: 65 + 24 + 1 = 90 cycles from `line_start` to `done`.
- Zero hits: `done` 66 cycles after `line_start`.
- `busy` rises the cycle after `line_start` and falls the cycle after `done`.

## Configuration
- `SPR_OVERFLOW_EN` defined: overflow detection as described; SCAN terminates at the first hit beyond NUM_SLOTS.
- Not defined: `overflow` is tied to 0; hits beyond NUM_SLOTS are silently ignored and SCAN still runs all NUM_OAM entries (fixed timing).

## Test plan
- Reset: hold `reset_n`=0 mid-FETCH → all outputs 0 immediately; no `rend_now` pulse after release.
- One sprite: y=10, tile=0x42, x=100, attr=0x41, scanline=13, immediate ack, `pat_data`=0xA55A.
  - `pat_addr`=0x213.
  - `rend_buf`=0x4164A55A; `rend_now`=0x01 for one cycle.
  - `draw_en`=0x01; `done` at cycle 69.
- Vflip and wrap: y=250, attr=0x80, scanline=2 → row=8 is not a hit. With scanline=1 → row=7 and `pat_addr` row field = 0.
- Overflow: 9 hits at OAM 0..8, macro on.
  - `overflow`=1, `draw_en`=0xFF, slots hold OAM 0..7 in order.
  - SCAN ends after OAM 8 is compared.
  - Macro off: `overflow`=0 and SCAN still covers all 64 entries.
- Ack stall: `pat_ack` delayed 5 cycles → `pat_req` and `pat_addr` held stable for 6 cycles; `rend_now` follows 2 cycles after ack.
- Abort: `line_start` during FETCH of slot 3 → `rend_now`=0, `draw_en`=0, SCAN restarts at `oam_addr` 0; no `done` until the new pass completes.

Source files
------------

// File: rtl/spr_sched.sv
// spr_sched: per-line sprite evaluation and pattern-load scheduler for spr_rend.
// Define SPR_OVERFLOW_EN for overflow detection with early scan termination.
module spr_sched #(
    parameter int NUM_SLOTS = 8,
    parameter int NUM_OAM   = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 line_start,
    input  logic [7:0]           scanline,
    output logic [5:0]           oam_addr,
    input  logic [31:0]          oam_data,
    output logic                 pat_req,
    output logic [10:0]          pat_addr,
    input  logic                 pat_ack,
    input  logic [15:0]          pat_data,
    output logic [31:0]          rend_buf,
    output logic [NUM_SLOTS-1:0] rend_now,
    output logic [NUM_SLOTS-1:0] draw_en,
    output logic                 overflow,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(NUM_OAM + 1);
    localparam int HW = $clog2(NUM_SLOTS + 1);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        FETCH,
        LOAD,
        STROBE,
        DONE
    } state_t;

    state_t state;
    state_t next;

    logic [CW-1:0] scan_cnt;
    logic [7:0]    line_q;
    logic [HW-1:0] hit_cnt;
    logic [SW-1:0] slot;

    // Hit buffer; attr is kept as {vflip, hflip, priority, palette[1:0]}.
    logic [2:0] buf_row  [NUM_SLOTS];
    logic [7:0] buf_tile [NUM_SLOTS];
    logic [4:0] buf_attr [NUM_SLOTS];
    logic [7:0] buf_x    [NUM_SLOTS];

    logic [7:0] row_diff;
    logic       cmp_valid;
    logic       is_hit;
    logic       buf_full;
    logic       store;
    logic       spill;
    logic       scan_last;
    logic       scan_end;
    logic       has_hits;
    logic       last_slot;
    logic       enter_done;
    logic [4:0] cur_attr;
    logic [2:0] fetch_row;
    logic       unused_attr;

    // Entry fetched with address N is compared on the next cycle.
    assign row_diff    = line_q - oam_data[31:24];
    assign cmp_valid   = (state == SCAN) && (scan_cnt != '0);
    assign is_hit      = cmp_valid && (row_diff[7:3] == 5'd0);
    assign buf_full    = (hit_cnt == HW'(NUM_SLOTS));
    assign store       = is_hit && !buf_full;
    assign spill       = is_hit && buf_full;
    assign scan_last   = (scan_cnt == CW'(NUM_OAM));
    assign has_hits    = (hit_cnt != '0) || store;
    assign last_slot   = ((HW'(slot) + HW'(1)) == hit_cnt);
    assign cur_attr    = buf_attr[slot];
    assign fetch_row   = cur_attr[4] ? ~buf_row[slot] : buf_row[slot];
    assign enter_done  = (next == DONE) && (state != DONE);
    assign unused_attr = ^oam_data[12:10];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        next     = state;
        oam_addr = '0;
        pat_req  = 1'b0;
        pat_addr = '0;
        rend_now = '0;
        done     = 1'b0;
        busy     = (state != IDLE);
        unique case (state)
            IDLE: begin
                next = IDLE;
            end
            SCAN: begin
                if (!scan_last) begin
                    oam_addr = 6'(scan_cnt);
                end
                if (scan_end) begin
                    next = has_hits ? FETCH : DONE;
                end
            end
            FETCH: begin
                pat_req  = 1'b1;
                pat_addr = {buf_tile[slot], fetch_row};
                if (pat_ack) begin
                    next = LOAD;
                end
            end
            LOAD: begin
                next = STROBE;
            end
            STROBE: begin
                rend_now[slot] = 1'b1;
                next = last_slot ? DONE : FETCH;
            end
            DONE: begin
                done = 1'b1;
                next = IDLE;
            end
            default: begin
                next = IDLE;
            end
        endcase
        // A new line always restarts the evaluation from scratch.
        if (line_start) begin
            next = SCAN;
        end
    end

    // Scan counter, captured scanline, hit count and slot pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt <= '0;
            line_q   <= '0;
            hit_cnt  <= '0;
            slot     <= '0;
        end else if (line_start) begin
            scan_cnt <= '0;
            line_q   <= scanline;
            hit_cnt  <= '0;
            slot     <= '0;
        end else begin
            if (state == SCAN) begin
                scan_cnt <= scan_cnt + CW'(1);
            end
            if (store) begin
                hit_cnt <= hit_cnt + HW'(1);
            end
            if (state == STROBE) begin
                slot <= slot + SW'(1);
            end
        end
    end

    // Hit buffer fills in OAM order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                buf_row[i]  <= '0;
                buf_tile[i] <= '0;
                buf_attr[i] <= '0;
                buf_x[i]    <= '0;
            end
        end else if (store && !line_start) begin
            buf_row[hit_cnt[SW-1:0]]  <= row_diff[2:0];
            buf_tile[hit_cnt[SW-1:0]] <= oam_data[23:16];
            buf_attr[hit_cnt[SW-1:0]] <= {oam_data[15:13], oam_data[9:8]};
            buf_x[hit_cnt[SW-1:0]]    <= oam_data[7:0];
        end
    end

    // Render word loads on the ack edge so it holds through LOAD and STROBE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rend_buf <= '0;
        end else if (state == FETCH && pat_ack && !line_start) begin
            rend_buf <= {1'b0, cur_attr[3], cur_attr[2], 3'b000,
                         cur_attr[1:0], buf_x[slot], pat_data};
        end
    end

    // Draw enables: dropped at line start, set for loaded slots on completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            draw_en <= '0;
        end else if (line_start) begin
            draw_en <= '0;
        end else if (enter_done) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                draw_en[i] <= (HW'(i) < hit_cnt);
            end
        end
    end

`ifdef SPR_OVERFLOW_EN
    logic ovf_q;

    // Overflow latched during scan, published when the line completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q    <= 1'b0;
            overflow <= 1'b0;
        end else if (line_start) begin
            ovf_q <= 1'b0;
        end else begin
            if (spill) begin
                ovf_q <= 1'b1;
            end
            if (enter_done) begin
                overflow <= ovf_q;
            end
        end
    end

    assign scan_end = scan_last || spill;
`else
    logic unused_spill;

    assign overflow     = 1'b0;
    assign scan_end     = scan_last;
    assign unused_spill = spill;
`endif

endmodule

// File: tb/tb_spr_sched.sv
// tb_spr_sched: directed vectors and corner sequences for spr_sched.
// Build with SPR_OVERFLOW_EN to check the overflow variant.
module tb_spr_sched;

    localparam int NS = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        line_start = 1'b0;
    logic [7:0]  scanline = '0;
    logic [5:0]  oam_addr;
    logic [31:0] oam_data;
    logic        pat_req;
    logic [10:0] pat_addr;
    logic        pat_ack;
    logic [15:0] pat_data;
    logic [31:0] rend_buf;
    logic [NS-1:0] rend_now;
    logic [NS-1:0] draw_en;
    logic        overflow;
    logic        busy;
    logic        done;

    int applied = 0;
    int miscompares = 0;

    spr_sched #(.NUM_SLOTS(NS), .NUM_OAM(64)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .line_start(line_start),
        .scanline(scanline),
        .oam_addr(oam_addr),
        .oam_data(oam_data),
        .pat_req(pat_req),
        .pat_addr(pat_addr),
        .pat_ack(pat_ack),
        .pat_data(pat_data),
        .rend_buf(rend_buf),
        .rend_now(rend_now),
        .draw_en(draw_en),
        .overflow(overflow),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // OAM model: one-cycle read latency.
    logic [31:0] oam_mem [64];
    always @(posedge clk) oam_data <= oam_mem[oam_addr];

    // Pattern memory model with programmable ack latency.
    int          ack_dly = 0;
    int          wait_n = 0;
    bit          pd_mode = 1'b0;
    logic [15:0] pd_word = '0;
    always @(posedge clk) begin
        if (pat_req && !pat_ack) wait_n <= wait_n + 1;
        else wait_n <= 0;
    end
    assign pat_ack  = pat_req && (wait_n >= ack_dly);
    assign pat_data = pd_mode ? {5'b0, pat_addr} : pd_word;

    // Monitor, sampling 2 time units after each rising edge.
    int          cyc_abs = 0;
    int          t0 = 0;
    int          rel = 0;
    bit          mon_en = 1'b0;
    int          strobe_n, done_n, first_req, cur_len, req_len;
    logic [31:0] sb_buf [16];
    logic [NS-1:0] sb_now [16];
    int          sb_cyc [16];
    logic [10:0] addr0;
    bit          addr_bad = 1'b0;
    bit          buf_bad = 1'b0;
    bit          now_bad = 1'b0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_buf = '0;
    logic [NS-1:0] prev_now = '0;

    always begin
        @(posedge clk);
        cyc_abs++;
        #2;
        if (mon_en) begin
            rel = cyc_abs - t0;
            if (pat_req) begin
                if (!prev_req) begin
                    addr0 = pat_addr;
                    cur_len = 0;
                    if (first_req < 0) first_req = rel;
                end else if (pat_addr !== addr0) begin
                    addr_bad = 1'b1;
                end
                cur_len++;
                if (pat_ack) req_len = cur_len;
            end
            if (rend_now != '0) begin
                if (strobe_n < 16) begin
                    sb_buf[strobe_n] = rend_buf;
                    sb_now[strobe_n] = rend_now;
                    sb_cyc[strobe_n] = rel;
                end
                strobe_n++;
                if (rend_buf !== prev_buf) buf_bad = 1'b1;
                if (prev_now != '0 || !$onehot(rend_now)) now_bad = 1'b1;
            end
            if (done) done_n++;
        end
        prev_req = pat_req;
        prev_buf = rend_buf;
        prev_now = rend_now;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon_clear();
        strobe_n = 0;
        done_n = 0;
        first_req = -1;
        cur_len = 0;
        req_len = 0;
    endtask

    // Fill OAM with entries that never hit the given line.
    task automatic fill(input logic [7:0] sl);
        for (int i = 0; i < 64; i++) oam_mem[i] = {sl + 8'd100, 24'h0};
    endtask

    // Pulse line_start and wait (bounded) for done; returns relative cycle.
    task automatic run_line(input logic [7:0] sl, output int dcyc);
        @(negedge clk);
        mon_clear();
        t0 = cyc_abs;
        mon_en = 1'b1;
        scanline = sl;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        while (!done && (cyc_abs - t0) < 400) @(negedge clk);
        dcyc = done ? (cyc_abs - t0) : -1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  y;
        logic [7:0]  tile;
        logic [7:0]  attr;
        logic [7:0]  x;
        logic [7:0]  sl;
        logic [5:0]  idx;
        logic [15:0] pd;
        bit          hit;
        logic [10:0] addr;
        logic [31:0] word;
    } vec_t;

    vec_t vt [7];

    initial begin
        int dc;
        int n;
        int exp_first;
        int exp_done;
        logic [7:0] t8;
        logic [31:0] w;

        vt[0] = '{8'd10, 8'h42, 8'h41, 8'd100, 8'd13, 6'd0,
                  16'hA55A, 1'b1, 11'h213, 32'h4164A55A};
        vt[1] = '{8'd250, 8'h33, 8'h80, 8'h10, 8'd2, 6'd5,
                  16'h0000, 1'b0, 11'h000, 32'h0};
        vt[2] = '{8'd250, 8'h10, 8'h80, 8'h20, 8'd1, 6'd5,
                  16'h1234, 1'b1, 11'h080, 32'h00201234};
        vt[3] = '{8'd0, 8'hFF, 8'h23, 8'hFF, 8'd0, 6'd63,
                  16'hFFFF, 1'b1, 11'h7F8, 32'h23FFFFFF};
        vt[4] = '{8'd100, 8'h05, 8'hE2, 8'h80, 8'd107, 6'd30,
                  16'h0F0F, 1'b1, 11'h028, 32'h62800F0F};
        vt[5] = '{8'd100, 8'h05, 8'h00, 8'h80, 8'd99, 6'd30,
                  16'h0000, 1'b0, 11'h000, 32'h0};
        vt[6] = '{8'd20, 8'h7A, 8'h80, 8'h01, 8'd25, 6'd17,
                  16'h8001, 1'b1, 11'h3D2, 32'h00018001};

        fill(8'd0);
        mon_clear();

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_rend_buf", rend_buf, 32'h0);
        chk("rst_ctl", {oam_addr, pat_req, pat_addr, overflow, busy, done}, 0);
        chk("rst_strobes", {rend_now, draw_en}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-sprite vector table.
        for (int i = 0; i < 7; i++) begin
            fill(vt[i].sl);
            oam_mem[vt[i].idx] = {vt[i].y, vt[i].tile, vt[i].attr, vt[i].x};
            pd_mode = 1'b0;
            pd_word = vt[i].pd;
            ack_dly = 0;
            run_line(vt[i].sl, dc);
            chk($sformatf("v%0d_done_cyc", i), dc, vt[i].hit ? 69 : 66);
            chk($sformatf("v%0d_draw_en", i), draw_en, vt[i].hit ? 1 : 0);
            chk($sformatf("v%0d_overflow", i), overflow, 0);
            chk($sformatf("v%0d_strobes", i), strobe_n, vt[i].hit ? 1 : 0);
            chk($sformatf("v%0d_busy_after", i), busy, 0);
            if (vt[i].hit) begin
                chk($sformatf("v%0d_pat_addr", i), addr0, vt[i].addr);
                chk($sformatf("v%0d_rend_buf", i), sb_buf[0], vt[i].word);
                chk($sformatf("v%0d_rend_now", i), sb_now[0], 1);
                chk($sformatf("v%0d_strobe_cyc", i), sb_cyc[0], 68);
            end
        end

        // Ack stall of 5 cycles.
        fill(8'd13);
        oam_mem[0] = {8'd10, 8'h42, 8'h41, 8'd100};
        pd_word = 16'hA55A;
        ack_dly = 5;
        run_line(8'd13, dc);
        chk("stall_req_len", req_len, 6);
        chk("stall_pat_addr", addr0, 11'h213);
        chk("stall_strobe_cyc", sb_cyc[0], 73);
        chk("stall_rend_buf", sb_buf[0], 32'h4164A55A);
        chk("stall_done_cyc", dc, 74);
        ack_dly = 0;

        // Nine hits at OAM 0..8.
        fill(8'd13);
        for (int i = 0; i < 9; i++) begin
            t8 = 8'h10 + 8'(i);
            oam_mem[i] = {8'd10, t8, 6'b0, 2'(i), 8'(i * 10)};
        end
        pd_mode = 1'b1;
        run_line(8'd13, dc);
`ifdef SPR_OVERFLOW_EN
        exp_first = 11;
        exp_done = 35;
        chk("ovf_flag", overflow, 1);
`else
        exp_first = 66;
        exp_done = 90;
        chk("ovf_flag", overflow, 0);
`endif
        chk("ovf_first_fetch", first_req, exp_first);
        chk("ovf_done_cyc", dc, exp_done);
        chk("ovf_draw_en", draw_en, 8'hFF);
        chk("ovf_strobes", strobe_n, 8);
        for (int k = 0; k < 8; k++) begin
            t8 = 8'h10 + 8'(k);
            w = {6'b0, 2'(k), 8'(k * 10), 5'b0, t8, 3'd3};
            chk($sformatf("ovf_slot%0d_buf", k), sb_buf[k], w);
            chk($sformatf("ovf_slot%0d_now", k), sb_now[k], 32'(1) << k);
        end

        // Following empty line republishes overflow and draw enables.
        fill(8'd13);
        pd_mode = 1'b0;
        run_line(8'd13, dc);
        chk("empty_done_cyc", dc, 66);
        chk("empty_overflow", overflow, 0);
        chk("empty_draw_en", draw_en, 0);

        // Abort during FETCH of slot 3, then a clean restart.
        fill(8'd13);
        for (int i = 0; i < 5; i++) begin
            t8 = 8'h20 + 8'(i);
            oam_mem[i] = {8'd10, t8, 8'h00, 8'(i)};
        end
        pd_mode = 1'b1;
        ack_dly = 10;
        @(negedge clk);
        mon_clear();
        t0 = cyc_abs;
        mon_en = 1'b1;
        scanline = 8'd13;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        n = 0;
        while (!(strobe_n == 3 && pat_req) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_slot3", n < 300, 1);
        mon_clear();
        t0 = cyc_abs;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        ack_dly = 0;
        chk("abort_rend_now", rend_now, 0);
        chk("abort_draw_en", draw_en, 0);
        chk("abort_pat_req", pat_req, 0);
        chk("abort_busy", busy, 1);
        chk("abort_oam_addr0", oam_addr, 0);
        @(negedge clk);
        chk("abort_oam_addr1", oam_addr, 1);
        while (!done && (cyc_abs - t0) < 400) @(negedge clk);
        dc = done ? (cyc_abs - t0) : -1;
        chk("abort_done_cyc", dc, 81);
        chk("abort_strobes", strobe_n, 5);
        chk("abort_draw_en_end", draw_en, 8'h1F);

        // Reset asserted mid-FETCH.
        fill(8'd13);
        oam_mem[0] = {8'd10, 8'h42, 8'h41, 8'd100};
        pd_mode = 1'b0;
        ack_dly = 20;
        @(negedge clk);
        @(negedge clk);
        mon_clear();
        t0 = cyc_abs;
        scanline = 8'd13;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        n = 0;
        while (!pat_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reach_fetch", n < 200, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {oam_addr, pat_req, pat_addr, overflow, busy, done}, 0);
        chk("rst_mid_strobes", {rend_now, draw_en}, 0);
        chk("rst_mid_rend_buf", rend_buf, 32'h0);
        repeat (2) @(negedge clk);
        ack_dly = 0;
        reset_n = 1'b1;
        mon_clear();
        repeat (100) @(negedge clk);
        chk("rst_mid_no_strobe", strobe_n, 0);
        chk("rst_mid_no_done", done_n, 0);
        chk("rst_mid_idle", {busy, pat_req}, 0);
        mon_en = 1'b0;

        chk("pat_addr_stable", addr_bad, 0);
        chk("rend_buf_stable", buf_bad, 0);
        chk("rend_now_single", now_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule
